mdu_rf_sequencer: RTL and testbench

//  Multi-cycle M-extension execution sequencer that owns the register-file ports while an op is in flight.
//  - Accepts one decoded M op (funct3, rs1, rs2, rd) through a valid/ready handshake.
//  - Reads both operands from the register file and runs an iterative multiply or divide, 1 bit per cycle.
//  - Writes the result back to rd.
//  - Sits between decode and register_file; decode stalls while req_ready=0.

---
 rtl/riscv_m_pkg.sv | 32 +++
 rtl/mdu_iter_core.sv | 75 +++++++
 rtl/mdu_rf_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mdu_rf_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 codes, FSM states, and default widths.
// Also holds small helpers that say which operands a funct3 treats as signed.
package riscv_m_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply step or one restoring divide step per cycle.
// Outputs are the post-step values, so the caller can register a result on the final step edge.
module mdu_iter_core #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic                is_div,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic [2*XLEN-1:0]   product,
    output logic [XLEN-1:0]     quotient,
    output logic [XLEN-1:0]     remainder
);

    logic                is_div_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   mcand_reg;
    // Multiplier bits for MUL (shifted right each step), fixed divisor for DIV.
    logic [XLEN-1:0]     mplier_reg;
    logic [XLEN-1:0]     quo_reg;
    logic [XLEN-1:0]     quo_next;
    logic [XLEN-1:0]     rem_reg;
    logic [XLEN-1:0]     rem_next;
    logic [XLEN:0]       shifted;
    logic [XLEN:0]       trial;

    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        shifted  = {rem_reg, quo_reg[XLEN-1]};
        trial    = shifted - {1'b0, mplier_reg};
        if (trial[XLEN]) begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo_reg[XLEN-2:0], 1'b0};
        end else begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo_reg[XLEN-2:0], 1'b1};
        end
    end

    assign product   = acc_next;
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_reg <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
        end else if (start) begin
            is_div_reg <= is_div;
            acc_reg    <= '0;
            mcand_reg  <= {{XLEN{1'b0}}, op_a};
            mplier_reg <= op_b;
            quo_reg    <= op_a;
            rem_reg    <= '0;
        end else if (step) begin
            if (is_div_reg) begin
                quo_reg <= quo_next;
                rem_reg <= rem_next;
            end else begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
            end
        end
    end

endmodule

// File: rtl/mdu_rf_sequencer.sv
// M-extension op sequencer: accepts one op, reads operands, iterates, writes back rd.
// Signs are stripped before the unsigned core and reapplied on the way out.
module mdu_rf_sequencer
    import riscv_m_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [REG_ADDR_W-1:0] req_rs1,
    input  logic [REG_ADDR_W-1:0] req_rs2,
    input  logic [REG_ADDR_W-1:0] req_rd,
    output logic [REG_ADDR_W-1:0] rf_rs1,
    output logic [REG_ADDR_W-1:0] rf_rs2,
    output logic                  rf_rs1_rd_en,
    output logic                  rf_rs2_rd_en,
    input  logic [XLEN-1:0]       rf_rS1,
    input  logic [XLEN-1:0]       rf_rS2,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic                  rf_rd_wd_en,
    output logic [XLEN-1:0]       rf_rD,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(XLEN);

    state_t                  state_reg, state_next;
    logic [2:0]              funct3_reg;
    logic [REG_ADDR_W-1:0]   rd_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    neg_reg;

    logic                    req_ready_reg, req_ready_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    rd_en_reg, rd_en_next;
    logic [REG_ADDR_W-1:0]   rf_rs1_reg, rf_rs1_next;
    logic [REG_ADDR_W-1:0]   rf_rs2_reg, rf_rs2_next;
    logic [REG_ADDR_W-1:0]   rf_rd_reg, rf_rd_next;
    logic                    wd_en_reg, wd_en_next;
    logic [XLEN-1:0]         rf_wd_reg, rf_wd_next;

    logic                    is_div, is_rem, rs1_neg, rs2_neg;
    logic                    div_by_zero, div_overflow, special;
    logic [XLEN-1:0]         int_min, mag_a, mag_b, special_result;
    logic [2*XLEN-1:0]       product, prod_signed;
    logic [XLEN-1:0]         quotient, remainder, div_mag, div_result, mul_result, exec_result;

    // Operand conditioning; only meaningful while READ has the register file data on rf_rS1/rf_rS2.
    assign int_min      = {1'b1, {(XLEN-1){1'b0}}};
    assign is_div       = funct3_reg[2];
    assign is_rem       = funct3_reg[2] & funct3_reg[1];
    assign rs1_neg      = f3_rs1_signed(funct3_reg) & rf_rS1[XLEN-1];
    assign rs2_neg      = f3_rs2_signed(funct3_reg) & rf_rS2[XLEN-1];
    assign mag_a        = rs1_neg ? -rf_rS1 : rf_rS1;
    assign mag_b        = rs2_neg ? -rf_rS2 : rf_rS2;
    assign div_by_zero  = is_div && (rf_rS2 == '0);
    assign div_overflow = is_div && !funct3_reg[0] && (rf_rS1 == int_min) && (rf_rS2 == '1);
    assign special      = div_by_zero | div_overflow;

    always_comb begin
        if (div_by_zero) special_result = is_rem ? rf_rS1 : '1;
        else             special_result = is_rem ? '0 : int_min;
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (state_reg == ST_READ),
        .step      (state_reg == ST_EXEC),
        .is_div    (is_div),
        .op_a      (mag_a),
        .op_b      (mag_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign prod_signed = neg_reg ? -product : product;
    assign mul_result  = (funct3_reg == F3_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    assign div_mag     = funct3_reg[1] ? remainder : quotient;
    assign div_result  = neg_reg ? -div_mag : div_mag;
    assign exec_result = is_div ? div_result : mul_result;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_en_reg     <= 1'b0;
            rf_rs1_reg    <= '0;
            rf_rs2_reg    <= '0;
            rf_rd_reg     <= '0;
            wd_en_reg     <= 1'b0;
            rf_wd_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            rd_en_reg     <= rd_en_next;
            rf_rs1_reg    <= rf_rs1_next;
            rf_rs2_reg    <= rf_rs2_next;
            rf_rd_reg     <= rf_rd_next;
            wd_en_reg     <= wd_en_next;
            rf_wd_reg     <= rf_wd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_reg <= '0;
            rd_reg     <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && req_valid) begin
                funct3_reg <= req_funct3;
                rd_reg     <= req_rd;
            end
            if (state_reg == ST_READ) begin
                cnt_reg <= '0;
                neg_reg <= is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
            end else if (state_reg == ST_EXEC) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_valid) state_next = ST_READ;
            ST_READ: state_next = special ? ST_WB : ST_EXEC;
            ST_EXEC: if (cnt_reg == CNT_W'(XLEN-1)) state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are derived from the upcoming state so they line up with it after the edge.
    always_comb begin
        req_ready_next = (state_next == ST_IDLE);
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_WB);
        rd_en_next     = (state_next == ST_READ);
        rf_rs1_next    = (state_next == ST_READ) ? req_rs1 : '0;
        rf_rs2_next    = (state_next == ST_READ) ? req_rs2 : '0;
        rf_rd_next     = (state_next == ST_WB) ? rd_reg : '0;
        wd_en_next     = (state_next == ST_WB) && (rd_reg != '0);
        rf_wd_next     = '0;
        if (state_next == ST_WB)
            rf_wd_next = (state_reg == ST_READ) ? special_result : exec_result;
    end

    assign req_ready    = req_ready_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign rf_rs1_rd_en = rd_en_reg;
    assign rf_rs2_rd_en = rd_en_reg;
    assign rf_rs1       = rf_rs1_reg;
    assign rf_rs2       = rf_rs2_reg;
    assign rf_rd        = rf_rd_reg;
    assign rf_rD        = rf_wd_reg;
    // A reset arriving during WB must suppress that cycle's write, so the enable is masked by rst.
    assign rf_rd_wd_en  = wd_en_reg & ~rst;

endmodule

// File: tb/tb_mdu_rf_sequencer.sv
// Bench for mdu_rf_sequencer: directed ops pinned by literal results, then randomized traffic
// compared every cycle against an arithmetic model of the op timeline.
module tb_mdu_rf_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic        rf_rs1_rd_en, rf_rs2_rd_en, rf_rd_wd_en;
    logic [31:0] rf_rS1, rf_rS2, rf_rD;
    logic        busy, done;

    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state
    bit          m_busy = 0;
    int          m_k = 0;
    int          m_wbk = 0;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_res;

    // Literal expectations for directed ops
    int          lit_tag = 0;
    int          lit_seen = 0;
    int          lit_k = 0;
    logic [31:0] lit_val = '0;

    always #5 clk = ~clk;

    mdu_rf_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rd       (req_rd),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rs1_rd_en (rf_rs1_rd_en),
        .rf_rs2_rd_en (rf_rs2_rd_en),
        .rf_rS1       (rf_rS1),
        .rf_rS2       (rf_rS2),
        .rf_rd        (rf_rd),
        .rf_rd_wd_en  (rf_rd_wd_en),
        .rf_rD        (rf_rD),
        .busy         (busy),
        .done         (done)
    );

    assign rf_rS1 = regs[rf_rs1];
    assign rf_rS2 = regs[rf_rs2];

    // Returns {special, result} straight from the RISC-V M arithmetic rules.
    function automatic logic [32:0] ref_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int ai;
        int bi;
        longint la;
        longint lb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] p;
        logic [31:0] q;
        ai = a; bi = b; la = ai; lb = bi; ua = {32'b0, a}; ub = {32'b0, b};
        p = '0; q = '0;
        case (f3)
            3'd0: begin p = ua * ub; return {1'b0, p[31:0]}; end
            3'd1: begin p = la * lb; return {1'b0, p[63:32]}; end
            3'd2: begin p = la * longint'(ub); return {1'b0, p[63:32]}; end
            3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
            3'd4: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
                q = ai / bi; return {1'b0, q};
            end
            3'd5: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                q = a / b; return {1'b0, q};
            end
            3'd6: begin
                if (b == 0) return {1'b1, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h0};
                q = ai % bi; return {1'b0, q};
            end
            default: begin
                if (b == 0) return {1'b1, a};
                q = a % b; return {1'b0, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = ref_calc(f3, a, b);
        return r[31:0];
    endfunction

    function automatic int ref_wbk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = ref_calc(f3, a, b);
        return r[32] ? 2 : 34;
    endfunction

    // Op timeline model: k counts cycles since the accepting edge.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1;
                m_k    <= 1;
                m_rs1  <= req_rs1;
                m_rs2  <= req_rs2;
                m_rd   <= req_rd;
                m_res  <= ref_res(req_funct3, regs[req_rs1], regs[req_rs2]);
                m_wbk  <= ref_wbk(req_funct3, regs[req_rs1], regs[req_rs2]);
            end
        end else if (m_k == m_wbk) begin
            m_busy <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_rd, e_done, e_wd;
            e_rd   = m_busy && (m_k == 1);
            e_done = m_busy && (m_k == m_wbk);
            e_wd   = e_done && (m_rd != 0) && !rst;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("rs1_rd_en", 32'(rf_rs1_rd_en), 32'(e_rd));
            chk("rs2_rd_en", 32'(rf_rs2_rd_en), 32'(e_rd));
            chk("rf_rs1", 32'(rf_rs1), e_rd ? 32'(m_rs1) : 32'd0);
            chk("rf_rs2", 32'(rf_rs2), e_rd ? 32'(m_rs2) : 32'd0);
            chk("wd_en", 32'(rf_rd_wd_en), 32'(e_wd));
            chk("rf_rd", 32'(rf_rd), e_done ? 32'(m_rd) : 32'd0);
            chk("rf_rD", rf_rD, e_done ? m_res : 32'd0);
            if (lit_tag != lit_seen && m_busy && m_k == lit_k) begin
                chk("lit_done", 32'(done), 32'd1);
                chk("lit_rD", rf_rD, lit_val);
                lit_seen <= lit_tag;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] lv, input int lk);
        @(posedge clk); #2;
        wait_idle();
        req_funct3 = f3; req_rs1 = s1; req_rs2 = s2; req_rd = d;
        lit_val = lv; lit_k = lk; lit_tag = lit_tag + 1;
        req_valid = 1;
        @(posedge clk); #2;
        req_valid = 0;
        wait_idle();
    endtask

    initial begin
        int n;
        init_regs();
        rst = 1; req_valid = 0; req_funct3 = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
        @(posedge clk); #2;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // 1: MUL 6*7
        issue(3'd0, 5'd6, 5'd7, 5'd10, 32'd42, 34);
        // 2: high-half multiplies with x31 = -1
        regs[31] = 32'hFFFF_FFFF;
        issue(3'd1, 5'd31, 5'd2, 5'd5, 32'hFFFF_FFFF, 34);
        issue(3'd3, 5'd31, 5'd2, 5'd5, 32'h0000_0001, 34);
        issue(3'd2, 5'd31, 5'd2, 5'd5, 32'hFFFF_FFFF, 34);
        issue(3'd0, 5'd31, 5'd2, 5'd5, 32'hFFFF_FFFE, 34);
        // 3: divides
        issue(3'd5, 5'd20, 5'd3, 5'd5, 32'd6, 34);
        issue(3'd7, 5'd20, 5'd3, 5'd5, 32'd2, 34);
        regs[20] = 32'hFFFF_FFEC;
        issue(3'd4, 5'd20, 5'd3, 5'd5, 32'hFFFF_FFFA, 34);
        issue(3'd6, 5'd20, 5'd3, 5'd5, 32'hFFFF_FFFE, 34);
        // 4: special cases resolved in READ
        issue(3'd4, 5'd9, 5'd0, 5'd5, 32'hFFFF_FFFF, 2);
        issue(3'd6, 5'd9, 5'd0, 5'd5, 32'd9, 2);
        regs[9] = 32'h8000_0000; regs[1] = 32'hFFFF_FFFF;
        issue(3'd4, 5'd9, 5'd1, 5'd5, 32'h8000_0000, 2);
        issue(3'd6, 5'd9, 5'd1, 5'd5, 32'd0, 2);
        init_regs();

        // 5: rd=0 with req_valid held through the whole op
        @(posedge clk); #2;
        req_funct3 = 3'd0; req_rs1 = 5'd6; req_rs2 = 5'd7; req_rd = 5'd0;
        lit_val = 32'd42; lit_k = 34; lit_tag = lit_tag + 1;
        req_valid = 1;
        repeat (36) begin @(posedge clk); #2; end
        req_valid = 0;
        wait_idle();

        // 6: reset in the middle of a DIVU, then a clean MUL
        @(posedge clk); #2;
        req_funct3 = 3'd5; req_rs1 = 5'd20; req_rs2 = 5'd3; req_rd = 5'd8;
        req_valid = 1;
        @(posedge clk); #2;
        req_valid = 0;
        n = 0;
        while (m_k != 10 && n < 20) begin @(posedge clk); #2; n++; end
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        issue(3'd0, 5'd6, 5'd7, 5'd11, 32'd42, 34);

        // Randomized traffic, including resets and held requests
        for (int ep = 0; ep < 20; ep++) begin
            req_valid = 0; rst = 0;
            @(posedge clk); #2;
            wait_idle();
            for (int i = 1; i < 32; i++) begin
                case ($urandom_range(0, 5))
                    0: regs[i] = 32'h0;
                    1: regs[i] = 32'hFFFF_FFFF;
                    2: regs[i] = 32'h8000_0000;
                    3: regs[i] = 32'($urandom_range(0, 20));
                    default: regs[i] = $urandom;
                endcase
            end
            for (int c = 0; c < 150; c++) begin
                req_valid  = ($urandom_range(0, 2) != 0);
                req_funct3 = 3'($urandom_range(0, 7));
                req_rs1    = 5'($urandom_range(0, 31));
                req_rs2    = 5'($urandom_range(0, 31));
                req_rd     = 5'($urandom_range(0, 31));
                rst        = ($urandom_range(0, 149) == 0);
                @(posedge clk); #2;
            end
        end
        req_valid = 0; rst = 0;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
